// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI/host RAM arbiter.
// cmd_e       : SPI command field rx_data[9:8]
// arb_state_e : arbiter FSM states
// grant_e     : which requester was served last (round-robin memory)
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_SPI_WR,
    ARB_SPI_RD,
    ARB_SPI_RSP,
    ARB_HOST,
    ARB_HOST_RSP
  } arb_state_e;

  typedef enum logic {
    SPI  = 1'b0,
    HOST = 1'b1
  } grant_e;

endpackage

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: detects new words on the rx_valid rising edge, keeps the
// write/read address registers, the single pending-operation slot and the
// sticky overflow flag.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid from the SPI slave;
// issue_wr/issue_rd pulse while the arbiter issues the pending op (clears the
// slot); capture, slot_* and spi_ovf go to the arbiter.
// Build option: SPI_AUTO_INC_EN advances the matching address after each issue.
module spi_cmd_decoder
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 issue_wr,
  input  logic                 issue_rd,
  output logic                 capture,
  output logic                 slot_valid,
  output logic                 slot_rd,
  output logic [ADDR_SIZE-1:0] slot_addr,
  output logic [DATA_W-1:0]    slot_data,
  output logic                 spi_ovf
);

  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
  logic                 slot_valid_q, slot_rd_q, spi_ovf_q;
  logic [ADDR_SIZE-1:0] slot_addr_q;
  logic [DATA_W-1:0]    slot_data_q;
  cmd_e                 cmd;

  assign capture = rx_valid & ~rx_valid_q;
  assign cmd     = cmd_e'(rx_data[9:8]);

`ifdef SPI_AUTO_INC_EN
  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      slot_valid_q <= 1'b0;
      slot_rd_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      spi_ovf_q    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
`ifdef SPI_AUTO_INC_EN
      // Written before the capture decode so an address command wins.
      if (issue_wr) wr_addr_q <= addr_inc(wr_addr_q);
      if (issue_rd) rd_addr_q <= addr_inc(rd_addr_q);
`endif
      if (issue_wr || issue_rd) slot_valid_q <= 1'b0;
      if (capture) begin
        unique case (cmd)
          CMD_WR_ADDR: wr_addr_q <= rx_data[ADDR_SIZE-1:0];
          CMD_RD_ADDR: rd_addr_q <= rx_data[ADDR_SIZE-1:0];
          CMD_WR_DATA: begin
            if (slot_valid_q) begin
              spi_ovf_q <= 1'b1;
            end else begin
              slot_valid_q <= 1'b1;
              slot_rd_q    <= 1'b0;
              slot_addr_q  <= wr_addr_q;
              slot_data_q  <= DATA_W'(rx_data[7:0]);
            end
          end
          CMD_RD_DATA: begin
            if (slot_valid_q) begin
              spi_ovf_q <= 1'b1;
            end else begin
              slot_valid_q <= 1'b1;
              slot_rd_q    <= 1'b1;
              slot_addr_q  <= rd_addr_q;
            end
          end
        endcase
      end
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_rd    = slot_rd_q;
  assign slot_addr  = slot_addr_q;
  assign slot_data  = slot_data_q;
  assign spi_ovf    = spi_ovf_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Command controller between an SPI slave and a single-port synchronous RAM,
// sharing the RAM round-robin with a local host port.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid in, tx_data/tx_valid
// out (SPI side); host_req/we/addr/wdata in, host_gnt/rvalid/rdata out;
// mem_en/we/addr/wdata out, mem_rdata in (1-cycle read latency); spi_ovf out.
// Build option: SPI_AUTO_INC_EN (see spi_cmd_decoder).
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 spi_ovf
);

  arb_state_e           state_q;
  grant_e               last_grant_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q, host_rvalid_q;
  logic [DATA_W-1:0]    host_rdata_q;
  logic                 capture, slot_valid, slot_rd;
  logic [ADDR_SIZE-1:0] slot_addr;
  logic [DATA_W-1:0]    slot_data;
  logic                 issue_wr, issue_rd;

  assign issue_wr = (state_q == ARB_SPI_WR);
  assign issue_rd = (state_q == ARB_SPI_RD);

  spi_cmd_decoder #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_W   (DATA_W)
  ) u_dec (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .issue_wr  (issue_wr),
    .issue_rd  (issue_rd),
    .capture   (capture),
    .slot_valid(slot_valid),
    .slot_rd   (slot_rd),
    .slot_addr (slot_addr),
    .slot_data (slot_data),
    .spi_ovf   (spi_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= HOST;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= 1'b0;
      // A fresh read response in the same cycle overrides the clear below.
      if (capture) tx_valid_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          // On contention the side not served last wins.
          if (slot_valid && (!host_req || last_grant_q == HOST)) begin
            state_q <= slot_rd ? ARB_SPI_RD : ARB_SPI_WR;
          end else if (host_req) begin
            state_q <= ARB_HOST;
          end
        end
        ARB_SPI_WR: begin
          last_grant_q <= SPI;
          state_q      <= ARB_IDLE;
        end
        ARB_SPI_RD: begin
          last_grant_q <= SPI;
          state_q      <= ARB_SPI_RSP;
        end
        ARB_SPI_RSP: begin
          tx_data_q  <= mem_rdata[7:0];
          tx_valid_q <= 1'b1;
          state_q    <= ARB_IDLE;
        end
        ARB_HOST: begin
          last_grant_q <= HOST;
          state_q      <= host_we ? ARB_IDLE : ARB_HOST_RSP;
        end
        ARB_HOST_RSP: begin
          host_rdata_q  <= mem_rdata;
          host_rvalid_q <= 1'b1;
          state_q       <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // RAM port and grant decoded from state; forced low while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    host_gnt  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ARB_SPI_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = slot_addr;
          mem_wdata = slot_data;
        end
        ARB_SPI_RD: begin
          mem_en   = 1'b1;
          mem_addr = slot_addr;
        end
        ARB_HOST: begin
          mem_en    = 1'b1;
          mem_we    = host_we;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
          host_gnt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       spi_ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  ram [256];
  logic [17:0] ev_q [$];  // {host_gnt, mem_we, mem_addr, mem_wdata} per RAM access

  always #5 clk = ~clk;

  spi_ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .spi_ovf    (spi_ovf)
  );

  // Synchronous RAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_en) ev_q.push_back({host_gnt, mem_we, mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_send(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    int n;
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    n = 0;
    while (!host_gnt && n < 10) begin tick(); n++; end
    check("hw_gnt", 32'(host_gnt), 32'd1);
    tick();
    host_req = 1'b0; host_we = 1'b0; host_wdata = '0;
  endtask

  // SPI data word captured one cycle before a host read of `a` is raised.
  task automatic conflict(input logic [9:0] w, input logic [7:0] a,
                          output logic rv, output logic [7:0] rd);
    int n;
    rx_data = w; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = a; host_wdata = '0;
    n = 0; rv = 1'b0; rd = '0;
    while (n < 20 && !rv) begin
      tick(); n++;
      if (host_gnt) host_req = 1'b0;
      if (host_rvalid) begin rv = 1'b1; rd = host_rdata; end
    end
    host_req = 1'b0;
  endtask

  initial begin
    int n;
    int spi_wr;
    logic rv;
    logic [7:0] rd;

    // Reset state
    tick();
    check("rst_mem_en", 32'(mem_en), 0);
    tick();
    rst = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_host_gnt", 32'(host_gnt), 0);
    check("rst_rvalid", 32'(host_rvalid), 0);
    check("rst_ovf", 32'(spi_ovf), 0);

    // SPI write 0x05 <= 0xA5
    ev_q.delete();
    spi_send(10'h005);
    spi_send(10'h1A5);
    repeat (4) tick();
    check("wr_nev", ev_q.size(), 1);
    check("wr_ev", 32'(ev_q[0]), 32'({1'b0, 1'b1, 8'h05, 8'hA5}));
    check("wr_ram", 32'(ram[8'h05]), 32'hA5);

    // SPI read of 0x05
    ev_q.delete();
    spi_send(10'h205);
    rx_data = 10'h300; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    n = 0;
    while (!tx_valid && n < 10) begin tick(); n++; end
    check("rd_lat", n, 2);
    check("rd_data", 32'(tx_data), 32'hA5);
    check("rd_ev", 32'(ev_q[0]), 32'({1'b0, 1'b0, 8'h05, 8'h00}));
    repeat (3) tick();
    check("rd_hold", 32'(tx_valid), 1);
    rx_data = 10'h005; rx_valid = 1'b1;
    tick();
    check("rd_clear", 32'(tx_valid), 0);
    rx_valid = 1'b0;
    tick();

    // Contention after reset: SPI first
    do_reset();
    host_write(8'h10, 8'h3C);
    spi_send(10'h020);
    ev_q.delete();
    conflict(10'h177, 8'h10, rv, rd);
    repeat (3) tick();
    check("arb1_rvalid", 32'(rv), 1);
    check("arb1_rdata", 32'(rd), 32'h3C);
    check("arb1_nev", ev_q.size(), 2);
    check("arb1_first", 32'(ev_q[0]), 32'({1'b0, 1'b1, 8'h20, 8'h77}));
    check("arb1_second", 32'(ev_q[1]), 32'({1'b1, 1'b0, 8'h10, 8'h00}));

    // Contention with last grant SPI: host first
    spi_send(10'h020);
    spi_send(10'h144);
    repeat (4) tick();
    spi_send(10'h020);
    ev_q.delete();
    conflict(10'h155, 8'h10, rv, rd);
    repeat (4) tick();
    check("arb2_rdata", 32'(rd), 32'h3C);
    check("arb2_nev", ev_q.size(), 2);
    check("arb2_first", 32'(ev_q[0]), 32'({1'b1, 1'b0, 8'h10, 8'h00}));
    check("arb2_second", 32'(ev_q[1]), 32'({1'b0, 1'b1, 8'h20, 8'h55}));

    // Overflow with the host issuing back-to-back reads
    do_reset();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    spi_send(10'h030);
    ev_q.delete();
    spi_send(10'h1B1);
    spi_send(10'h1B2);
    repeat (12) tick();
    host_req = 1'b0;
    repeat (4) tick();
    spi_wr = 0;
    foreach (ev_q[i]) if (!ev_q[i][17]) spi_wr++;
    check("ovf_flag", 32'(spi_ovf), 1);
    check("ovf_nwr", spi_wr, 1);
    check("ovf_ram", 32'(ram[8'h30]), 32'hB1);
    repeat (3) tick();
    check("ovf_sticky", 32'(spi_ovf), 1);
    do_reset();
    check("ovf_rst", 32'(spi_ovf), 0);

    // Reset while the SPI read response is being returned
    spi_send(10'h205);
    rx_data = 10'h300; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check("rsp_rst_mem_en", 32'(mem_en), 0);
    tick();
    ev_q.delete();
    check("rsp_rst_tx", 32'(tx_valid), 0);
    check("rsp_rst_gnt", 32'(host_gnt), 0);
    check("rsp_rst_rvalid", 32'(host_rvalid), 0);
    rst = 1'b0;
    repeat (5) tick();
    check("rsp_rst_tx_after", 32'(tx_valid), 0);
    check("rsp_rst_noacc", ev_q.size(), 0);

`ifdef SPI_AUTO_INC_EN
    do_reset();
    ev_q.delete();
    spi_send(10'h0FF);
    spi_send(10'h111);
    repeat (4) tick();
    spi_send(10'h122);
    repeat (4) tick();
    check("inc_nev", ev_q.size(), 2);
    check("inc_first", 32'(ev_q[0]), 32'({1'b0, 1'b1, 8'hFF, 8'h11}));
    check("inc_wrap", 32'(ev_q[1]), 32'({1'b0, 1'b1, 8'h00, 8'h22}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
